morse_tx_queued: RTL and testbench

MORSE_TX_QUEUED -- requirements
Module: morse_tx_queued

---
 rtl/morse_tx_queued_if.sv | 11 +
 rtl/morse_tx_queued.sv | 191 +++++++++++++++++++
 tb/tb_morse_tx_queued.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/morse_tx_queued_if.sv
// Letter-queue handshake between a host and the Morse transmitter.
interface morse_tx_queued_if;
  logic       Start;
  logic [4:0] Letter;
  logic       Ready;
  logic       Overflow;
  logic       Invalid;

  modport master (output Start, Letter, input Ready, Overflow, Invalid);
  modport slave  (input Start, Letter, output Ready, Overflow, Invalid);
endinterface

// File: rtl/morse_tx_queued.sv
// Queued Morse keyer: letters A..Z are buffered in a small FIFO and keyed out
// one unit period per ClockIn/DIV, each followed by a 3-unit letter gap.
//
// state | meaning
// IDLE  | nothing to send, outputs quiet
// LOAD  | fetch next letter (queue pop, or last letter in repeat mode)
// SEND  | shifting the letter pattern out MSB-first
// GAP   | 3 silent unit periods after each letter
module morse_tx_queued #(
  parameter int CLOCK_FREQUENCY = 500,
  parameter int BIT_RATE_HZ     = 2,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic               ClockIn,
  input  logic               Reset,
  morse_tx_queued_if.slave   bus,
  input  logic               Repeat,
  output logic               DotDashOut,
  output logic               NewBitOut,
  output logic               Busy,
  output logic               Done
);

  localparam int DIV = CLOCK_FREQUENCY / BIT_RATE_HZ;
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = PW + 1;
  localparam logic [DW-1:0] DIV_RELOAD = DW'(DIV - 1);
  localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, SEND, GAP} state_t;

  // {pattern left-aligned, length in units}; dot=1, dash=111, element gap=0
  function automatic logic [20:0] rom(input logic [4:0] l);
    case (l)
      5'd0:  rom = {16'hB800, 5'd5};
      5'd1:  rom = {16'hEA80, 5'd9};
      5'd2:  rom = {16'hEBA0, 5'd11};
      5'd3:  rom = {16'hEA00, 5'd7};
      5'd4:  rom = {16'h8000, 5'd1};
      5'd5:  rom = {16'hAE80, 5'd9};
      5'd6:  rom = {16'hEE80, 5'd9};
      5'd7:  rom = {16'hAA00, 5'd7};
      5'd8:  rom = {16'hA000, 5'd3};
      5'd9:  rom = {16'hBBB8, 5'd13};
      5'd10: rom = {16'hEB80, 5'd9};
      5'd11: rom = {16'hBA80, 5'd9};
      5'd12: rom = {16'hEE00, 5'd7};
      5'd13: rom = {16'hE800, 5'd5};
      5'd14: rom = {16'hEEE0, 5'd11};
      5'd15: rom = {16'hBBA0, 5'd11};
      5'd16: rom = {16'hEEB8, 5'd13};
      5'd17: rom = {16'hBA00, 5'd7};
      5'd18: rom = {16'hA800, 5'd5};
      5'd19: rom = {16'hE000, 5'd3};
      5'd20: rom = {16'hAE00, 5'd7};
      5'd21: rom = {16'hAB80, 5'd9};
      5'd22: rom = {16'hBB80, 5'd9};
      5'd23: rom = {16'hEAE0, 5'd11};
      5'd24: rom = {16'hEBB8, 5'd13};
      5'd25: rom = {16'hEEA0, 5'd11};
      default: rom = {16'h0000, 5'd0};
    endcase
  endfunction

  state_t          state_q, state_d;
  logic [4:0]      mem_q [FIFO_DEPTH];
  logic [4:0]      mem_d [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [DW-1:0]   div_q, div_d;
  logic [15:0]     shift_q, shift_d;
  logic [4:0]      rem_q, rem_d;
  logic [4:0]      last_q, last_d;
  logic            rep_q, rep_d;
  logic            done_q, done_d, ovf_q, ovf_d, inv_q, inv_d;

  logic            valid, full, push, pop, strobe;
  logic [4:0]      sel;

  always_comb begin
    state_d  = state_q;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    div_d    = div_q;
    shift_d  = shift_q;
    rem_d    = rem_q;
    last_d   = last_q;
    rep_d    = rep_q;
    done_d   = 1'b0;
    sel      = rep_q ? last_q : mem_q[rd_ptr_q];

    // Admission uses the pre-pop count, so a full queue rejects even if LOAD pops now
    valid  = (bus.Letter <= 5'd25);
    full   = (count_q == DEPTH_C);
    push   = bus.Start && valid && !full;
    pop    = (state_q == LOAD) && !rep_q;
    inv_d  = bus.Start && !valid;
    ovf_d  = bus.Start && valid && full;
    strobe = ((state_q == SEND) || (state_q == GAP)) && (div_q == '0);

    if (push) begin
      mem_d[wr_ptr_q] = bus.Letter;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    count_d = count_q + CW'(push) - CW'(pop);

    case (state_q)
      IDLE: if (count_q != '0) state_d = LOAD;
      LOAD: begin
        {shift_d, rem_d} = rom(sel);
        last_d  = sel;
        div_d   = DIV_RELOAD;
        rep_d   = 1'b0;
        state_d = SEND;
      end
      SEND: begin
        div_d = strobe ? DIV_RELOAD : div_q - DW'(1);
        if (strobe) begin
          shift_d = {shift_q[14:0], 1'b0};
          if (rem_q == 5'd1) begin
            rem_d   = 5'd3;
            state_d = GAP;
          end else begin
            rem_d = rem_q - 5'd1;
          end
        end
      end
      GAP: begin
        div_d = strobe ? DIV_RELOAD : div_q - DW'(1);
        if (strobe) begin
          if (rem_q != 5'd1) begin
            rem_d = rem_q - 5'd1;
          end else if (count_q != '0) begin
            state_d = LOAD;
          end else if (Repeat) begin
            rep_d   = 1'b1;
            state_d = LOAD;
          end else begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ClockIn) begin
    if (Reset) begin
      state_q  <= IDLE;
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      div_q    <= '0;
      shift_q  <= '0;
      rem_q    <= '0;
      last_q   <= 5'd0;
      rep_q    <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      inv_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      div_q    <= div_d;
      shift_q  <= shift_d;
      rem_q    <= rem_d;
      last_q   <= last_d;
      rep_q    <= rep_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
      inv_q    <= inv_d;
    end
  end

  assign DotDashOut   = (state_q == SEND) && shift_q[15];
  assign NewBitOut    = strobe;
  assign Busy         = (state_q != IDLE);
  assign Done         = done_q;
  assign bus.Ready    = (count_q < DEPTH_C);
  assign bus.Overflow = ovf_q;
  assign bus.Invalid  = inv_q;

endmodule

// File: tb/tb_morse_tx_queued.sv
// Scoreboard bench for morse_tx_queued at default parameters (DIV=250, depth 4).
module tb_morse_tx_queued;

  logic ClockIn = 1'b0;
  logic Reset   = 1'b1;
  logic Repeat  = 1'b0;
  logic DotDashOut, NewBitOut, Busy, Done;

  morse_tx_queued_if bus ();

  morse_tx_queued dut (
    .ClockIn    (ClockIn),
    .Reset      (Reset),
    .bus        (bus),
    .Repeat     (Repeat),
    .DotDashOut (DotDashOut),
    .NewBitOut  (NewBitOut),
    .Busy       (Busy),
    .Done       (Done)
  );

  always #5 ClockIn = ~ClockIn;

  typedef struct {
    logic b;
    int   len;
  } unit_t;

  localparam int EV_DONE = 1;
  localparam int EV_OVF  = 2;
  localparam int EV_INV  = 3;

  unit_t exp_units[$];
  int    exp_events[$];
  int    checks   = 0;
  int    failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    failures++;
    $display("FAIL %s: seen but nothing expected", name);
  endtask

  // Hand-written key pattern, then the 3-unit gap. The first unit of each
  // letter spans the LOAD cycle as well, hence 251 busy cycles.
  task automatic push_letter(input string pat);
    for (int i = 0; i < pat.len(); i++)
      exp_units.push_back('{pat.getc(i) == "1", (i == 0) ? 251 : 250});
    for (int i = 0; i < 3; i++)
      exp_units.push_back('{1'b0, 250});
  endtask

  task automatic take_event(input int code, input string name);
    int e;
    if (exp_events.size() == 0) begin
      flag(name);
    end else begin
      e = exp_events.pop_front();
      chk(name, code, e);
    end
  endtask

  // Monitor: every strobe closes a unit period, every pulse consumes an event
  int    per_cnt = 0;
  int    ones    = 0;
  unit_t mon_u;

  always @(negedge ClockIn) begin
    if (Reset) begin
      per_cnt = 0;
      ones    = 0;
    end else begin
      if (Busy) begin
        per_cnt++;
        if (DotDashOut) ones++;
      end else begin
        chk("idle_key", DotDashOut, 0);
        chk("idle_strobe", NewBitOut, 0);
      end
      if (NewBitOut) begin
        if (exp_units.size() == 0) begin
          flag("unexpected_strobe");
        end else begin
          mon_u = exp_units.pop_front();
          chk("unit_len", per_cnt, mon_u.len);
          chk("unit_key_cycles", ones, mon_u.b ? 250 : 0);
        end
        per_cnt = 0;
        ones    = 0;
      end
      if (Done) begin
        take_event(EV_DONE, "done_pulse");
        chk("done_units_drained", exp_units.size(), 0);
        chk("done_busy_low", Busy, 0);
      end
      if (bus.Overflow) take_event(EV_OVF, "overflow_pulse");
      if (bus.Invalid)  take_event(EV_INV, "invalid_pulse");
    end
  end

  task automatic tick();
    @(posedge ClockIn);
    #1;
  endtask

  task automatic start(input logic [4:0] l);
    bus.Start  = 1'b1;
    bus.Letter = l;
    tick();
    bus.Start  = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int limit);
    int  n;
    bit  ok;
    n  = 0;
    ok = 1'b0;
    while (n < limit && !ok) begin
      tick();
      n++;
      ok = !Busy && exp_units.size() == 0 && exp_events.size() == 0;
    end
    chk(name, ok, 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_key"},      DotDashOut,   0);
    chk({tag, "_strobe"},   NewBitOut,    0);
    chk({tag, "_busy"},     Busy,         0);
    chk({tag, "_ready"},    bus.Ready,    1);
    chk({tag, "_done"},     Done,         0);
    chk({tag, "_overflow"}, bus.Overflow, 0);
    chk({tag, "_invalid"},  bus.Invalid,  0);
  endtask

  initial begin
    int n;
    bit seen;
    bus.Start  = 1'b0;
    bus.Letter = 5'd0;
    Reset      = 1'b1;
    tick();
    tick();
    chk_reset_outputs("rst");
    Reset = 1'b0;
    tick();

    // A from IDLE: latency, pattern 1/0/111, gap, single Done
    push_letter("10111");
    exp_events.push_back(EV_DONE);
    start(5'd0);
    chk("lat_pre_load_busy", Busy, 0);
    tick();
    chk("lat_load_busy", Busy, 1);
    chk("lat_load_key", DotDashOut, 0);
    tick();
    chk("lat_first_key", DotDashOut, 1);
    wait_idle("drain_A", 3000);

    // E, T, E back to back
    push_letter("1");
    push_letter("111");
    push_letter("1");
    exp_events.push_back(EV_DONE);
    start(5'd4);
    start(5'd19);
    start(5'd4);
    wait_idle("drain_ETE", 5000);

    // Fill the queue while busy, then overflow and an invalid code while full
    push_letter("111");
    start(5'd19);
    repeat (10) tick();
    push_letter("101");
    push_letter("10101");
    push_letter("11101");
    push_letter("1");
    exp_events.push_back(EV_OVF);
    exp_events.push_back(EV_INV);
    exp_events.push_back(EV_DONE);
    start(5'd8);
    start(5'd18);
    chk("ready_two_queued", bus.Ready, 1);
    start(5'd13);
    start(5'd4);
    chk("ready_full", bus.Ready, 0);
    start(5'd0);
    chk("overflow_now", bus.Overflow, 1);
    chk("ready_after_drop", bus.Ready, 0);
    start(5'd31);
    chk("invalid_now", bus.Invalid, 1);
    chk("invalid_over_overflow", bus.Overflow, 0);
    wait_idle("drain_queue", 10000);

    // Invalid code in IDLE
    exp_events.push_back(EV_INV);
    start(5'd26);
    chk("inv_idle_pulse", bus.Invalid, 1);
    chk("inv_idle_busy", Busy, 0);
    repeat (3) tick();
    chk("inv_idle_busy_later", Busy, 0);
    chk("inv_idle_ready", bus.Ready, 1);
    wait_idle("drain_invalid", 20);

    // Repeat mode: E three times, Repeat dropped during the third
    Repeat = 1'b1;
    push_letter("1");
    push_letter("1");
    push_letter("1");
    exp_events.push_back(EV_DONE);
    start(5'd4);
    n = 0;
    for (int k = 0; k < 4000 && n < 9; k++) begin
      tick();
      if (NewBitOut) n++;
    end
    chk("repeat_strobes_reached", n, 9);
    Repeat = 1'b0;
    wait_idle("drain_repeat", 5000);

    // Reset mid-SEND with two letters queued, Start in the reset cycle
    start(5'd0);
    start(5'd4);
    start(5'd19);
    repeat (98) tick();
    chk("pre_reset_busy", Busy, 1);
    chk("pre_reset_key", DotDashOut, 1);
    Reset      = 1'b1;
    bus.Start  = 1'b1;
    bus.Letter = 5'd4;
    tick();
    Reset     = 1'b0;
    bus.Start = 1'b0;
    chk_reset_outputs("midrst");
    seen = 1'b0;
    repeat (1200) begin
      tick();
      if (Busy || NewBitOut || DotDashOut) seen = 1'b1;
    end
    chk("post_reset_quiet", seen, 0);

    chk("scoreboard_empty", exp_units.size() + exp_events.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog: time limit reached, expected run to finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
